cpu_oci_trace_capture: RTL and testbench

//  Parametrised capture buffer for the Nios OCI debug-trace (DCT) stream. Samples
//  {dct_count, dct_buffer} whenever dct_count changes, stores entries in a FIFO and

---
 rtl/cpu_oci_trace_capture.sv | 105 ++++++++++
 tb/tb_cpu_oci_trace_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oci_trace_capture.sv
// Capture buffer for the Nios OCI debug-trace stream: records {dct_count, dct_buffer}
// on every count change and hands entries to a checker over a show-ahead valid/ready port.
module cpu_oci_trace_capture #(
   parameter int DATA_W    = 30,
   parameter int CNT_W     = 4,
   parameter int DEPTH     = 16,
   parameter bit WRAP_MODE = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            dct_buffer,
   input  logic [CNT_W-1:0]             dct_count,
   input  logic                         test_ending,
   input  logic                         test_has_ended,
   input  logic                         rd_ready,
   output logic                         rd_valid,
   output logic [CNT_W+DATA_W-1:0]      rd_data,
   output logic [$clog2(DEPTH):0]       fill_level,
   output logic                         overflow,
   output logic [15:0]                  dropped_count,
   output logic                         done
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = CNT_W + DATA_W;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] prev_count;
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [EW-1:0]    mem [DEPTH];

   logic empty;
   logic full;
   logic wr_req;
   logic pop;
   logic do_write;
   logic lost;
   logic overwrite;

   // The extra pointer MSB separates a full FIFO from an empty one.
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fill_level = wr_ptr - rd_ptr;

   assign rd_valid = !empty && (state != DONE);
   assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign done     = (state == DONE);
   assign pop      = rd_valid && rd_ready;

   // A same-cycle pop frees a slot, so a write into a full FIFO is only lossy without one.
   assign wr_req    = (state == CAPTURE) && !test_has_ended && (dct_count != prev_count);
   assign lost      = wr_req && full && !pop;
   assign overwrite = lost && WRAP_MODE;
   assign do_write  = wr_req && (!lost || WRAP_MODE);

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr[AW-1:0]] <= {dct_count, dct_buffer};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= CAPTURE;
         prev_count    <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         overflow      <= 1'b0;
         dropped_count <= '0;
      end else begin
         prev_count <= dct_count;
         if (test_has_ended) begin
            state  <= DONE;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            case (state)
               CAPTURE: if (test_ending) state <= DRAIN;
               DRAIN:   if (empty) state <= DONE;
               default: state <= DONE;
            endcase
            if (do_write) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop || overwrite) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (lost) begin
               overflow <= 1'b1;
               if (dropped_count != 16'hFFFF) begin
                  dropped_count <= dropped_count + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// Scoreboard bench for cpu_oci_trace_capture: one drop-mode and one wrap-mode instance
// (DEPTH=4) share the stimulus; a negedge monitor checks every popped entry.
module tb_cpu_oci_trace_capture;

   localparam int DATA_W = 30;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 4;
   localparam int FW     = $clog2(DEPTH) + 1;

   typedef logic [CNT_W+DATA_W-1:0] entry_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              test_ending;
   logic              test_has_ended;
   logic              rd_ready;

   logic              rd_valid_drop,  rd_valid_wrap;
   entry_t            rd_data_drop,   rd_data_wrap;
   logic [FW-1:0]     fill_drop,      fill_wrap;
   logic              overflow_drop,  overflow_wrap;
   logic [15:0]       dropped_drop,   dropped_wrap;
   logic              done_drop,      done_wrap;

   int n_checks = 0;
   int n_fail   = 0;

   entry_t q_drop[$];
   entry_t q_wrap[$];

   always #5 clk = ~clk;

   cpu_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(1'b0)) dut_drop (
      .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
      .rd_valid(rd_valid_drop), .rd_data(rd_data_drop), .fill_level(fill_drop),
      .overflow(overflow_drop), .dropped_count(dropped_drop), .done(done_drop));

   cpu_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(1'b1)) dut_wrap (
      .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
      .rd_valid(rd_valid_wrap), .rd_data(rd_data_wrap), .fill_level(fill_wrap),
      .overflow(overflow_wrap), .dropped_count(dropped_wrap), .done(done_wrap));

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input int cnt, input int payload);
      dct_count  = CNT_W'(cnt);
      dct_buffer = DATA_W'(payload);
   endtask

   function automatic entry_t mk(input int cnt, input int payload);
      return {CNT_W'(cnt), DATA_W'(payload)};
   endfunction

   task automatic reset_dut();
      rd_ready       = 1'b0;
      test_ending    = 1'b0;
      test_has_ended = 1'b0;
      dct_count      = '0;
      dct_buffer     = '0;
      reset          = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_rd_valid_drop"}, rd_valid_drop, 0);
      check_output({tag, "_rd_valid_wrap"}, rd_valid_wrap, 0);
      check_output({tag, "_rd_data_drop"},  rd_data_drop,  0);
      check_output({tag, "_rd_data_wrap"},  rd_data_wrap,  0);
      check_output({tag, "_fill_drop"},     fill_drop,     0);
      check_output({tag, "_fill_wrap"},     fill_wrap,     0);
      check_output({tag, "_overflow_drop"}, overflow_drop, 0);
      check_output({tag, "_overflow_wrap"}, overflow_wrap, 0);
      check_output({tag, "_dropped_drop"},  dropped_drop,  0);
      check_output({tag, "_dropped_wrap"},  dropped_wrap,  0);
      check_output({tag, "_done_drop"},     done_drop,     0);
      check_output({tag, "_done_wrap"},     done_wrap,     0);
   endtask

   // Every accepted read is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_valid_drop && rd_ready) begin
            if (q_drop.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL drop_unexpected_read: got %0h, expected no entry", rd_data_drop);
            end else begin
               check_output("drop_rd_data", rd_data_drop, q_drop.pop_front());
            end
         end
         if (rd_valid_wrap && rd_ready) begin
            if (q_wrap.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL wrap_unexpected_read: got %0h, expected no entry", rd_data_wrap);
            end else begin
               check_output("wrap_rd_data", rd_data_wrap, q_wrap.pop_front());
            end
         end
      end
   end

   initial begin
      int k;
      reset_dut();
      check_reset_values("reset");

      // Two count changes consumed immediately.
      rd_ready = 1'b1;
      apply_stimulus(1, 'h1);
      q_drop.push_back(mk(1, 'h1));
      q_wrap.push_back(mk(1, 'h1));
      @(negedge clk);
      check_output("t1_no_fallthrough_drop", rd_valid_drop, 0);
      check_output("t1_no_fallthrough_wrap", rd_valid_wrap, 0);
      step();
      apply_stimulus(2, 'h2);
      q_drop.push_back(mk(2, 'h2));
      q_wrap.push_back(mk(2, 'h2));
      @(negedge clk);
      check_output("t1_fill_a", fill_drop, 1);
      step();
      check_output("t1_fill_b", fill_drop, 1);
      check_output("t1_fill_b_wrap", fill_wrap, 1);
      step();
      check_output("t1_fill_end", fill_drop, 0);

      // Six changes with no reader: drop vs overwrite policy.
      reset_dut();
      for (int i = 1; i <= 6; i++) begin
         apply_stimulus(i, 'h10 + i);
         step();
      end
      check_output("t2_fill_drop", fill_drop, 4);
      check_output("t2_overflow_drop", overflow_drop, 1);
      check_output("t2_dropped_drop", dropped_drop, 2);
      check_output("t3_fill_wrap", fill_wrap, 4);
      check_output("t3_overflow_wrap", overflow_wrap, 1);
      check_output("t3_dropped_wrap", dropped_wrap, 2);
      for (int i = 1; i <= 4; i++) q_drop.push_back(mk(i, 'h10 + i));
      for (int i = 3; i <= 6; i++) q_wrap.push_back(mk(i, 'h10 + i));

      // Full FIFO: write and pop in the same cycle loses nothing.
      apply_stimulus(7, 'h17);
      rd_ready = 1'b1;
      q_drop.push_back(mk(7, 'h17));
      q_wrap.push_back(mk(7, 'h17));
      step();
      rd_ready = 1'b0;
      check_output("t4_fill_drop", fill_drop, 4);
      check_output("t4_fill_wrap", fill_wrap, 4);
      check_output("t4_dropped_drop", dropped_drop, 2);
      check_output("t4_dropped_wrap", dropped_wrap, 2);
      rd_ready = 1'b1;
      k = 0;
      while ((fill_drop != 0 || fill_wrap != 0) && k < 12) begin
         step();
         k++;
      end
      check_output("t4_drain_fill_drop", fill_drop, 0);
      check_output("t4_drain_fill_wrap", fill_wrap, 0);

      // Orderly end: count change after test_ending is ignored.
      reset_dut();
      for (int i = 1; i <= 3; i++) begin
         apply_stimulus(i, 'h20 + i);
         q_drop.push_back(mk(i, 'h20 + i));
         q_wrap.push_back(mk(i, 'h20 + i));
         step();
      end
      test_ending = 1'b1;
      step();
      test_ending = 1'b0;
      apply_stimulus(4, 'h24);
      step();
      step();
      check_output("t5_fill_after_ignored", fill_drop, 3);
      check_output("t5_done_early", done_drop, 0);
      rd_ready = 1'b1;
      k = 0;
      while (fill_drop != 0 && k < 12) begin
         step();
         k++;
      end
      check_output("t5_drained", fill_drop, 0);
      check_output("t5_done_not_yet", done_drop, 0);
      step();
      check_output("t5_done_drop", done_drop, 1);
      check_output("t5_done_wrap", done_wrap, 1);
      check_output("t5_rd_valid_done", rd_valid_drop, 0);

      // Hard end beats orderly end, then reset restores everything.
      reset_dut();
      apply_stimulus(1, 'h31);
      step();
      apply_stimulus(2, 'h32);
      step();
      check_output("t6_fill_before", fill_wrap, 2);
      test_has_ended = 1'b1;
      test_ending    = 1'b1;
      step();
      test_has_ended = 1'b0;
      test_ending    = 1'b0;
      check_output("t6_done_drop", done_drop, 1);
      check_output("t6_done_wrap", done_wrap, 1);
      check_output("t6_rd_valid", rd_valid_drop, 0);
      check_output("t6_fill", fill_drop, 0);
      check_output("t6_rd_data", rd_data_drop, 0);
      apply_stimulus(3, 'h33);
      rd_ready = 1'b1;
      step();
      step();
      check_output("t6_ignored_fill", fill_drop, 0);
      check_output("t6_done_held", done_drop, 1);
      reset_dut();
      check_reset_values("t6_reset");

      check_output("q_drop_empty", q_drop.size(), 0);
      check_output("q_wrap_empty", q_wrap.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
